// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side SRAM-like bus arbiter.
//   SZ_*      : access size encodings carried on *_size / mem_size
//   arb_state_e : transaction FSM states of the arbiter
//   OWN_*     : owner tag stored with the buffered request
//   RUN_W     : width of the data-run counter (supports MAX_DATA_RUN up to 15)
package cpu_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam int RUN_W = 4;

endpackage

// File: rtl/arb_priority_pick.sv
// Grant selection between fetch and data requesters plus the bounded-starvation
// run counter.
//   clk, resetn : clock / async active-low reset
//   pick_en     : arbiter is able to accept a request this cycle
//   inst_req    : fetch request
//   data_req    : data request
//   inst_gnt    : fetch granted this cycle (combinational)
//   data_gnt    : data granted this cycle (combinational)
module arb_priority_pick
  import cpu_bus_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic pick_en,
  input  logic inst_req,
  input  logic data_req,
  output logic inst_gnt,
  output logic data_gnt
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic             starve;

  always_comb begin
    run_d    = run_q;
    // Data keeps priority until it has won RUN_MAX times in a row over a
    // waiting fetch; then the fetch is forced through once.
    starve   = inst_req && (run_q == RUN_MAX);
    data_gnt = pick_en && data_req && !starve;
    inst_gnt = pick_en && inst_req && !data_gnt;

    if (inst_gnt) begin
      run_d = '0;
    end else if (data_gnt) begin
      if (!inst_req) begin
        run_d = '0;
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access,
// one outstanding transaction at a time, data side prioritised.
//   clk, resetn                : clock / async active-low reset
//   inst_req/addr              : fetch request (read only, word)
//   inst_addr_ok/data_ok/rdata : fetch handshake and read data
//   data_req/wr/size/addr/wdata: data request
//   data_addr_ok/data_ok/rdata : data handshake and read data
//   mem_req/wr/size/addr/wdata : request towards memory, held until mem_addr_ok
//   mem_addr_ok/data_ok/rdata  : memory handshake and read data
//   busy                       : a transaction is in flight
//
// state    | meaning
// ARB_IDLE | no transaction; arbitration and grant happen here
// ARB_REQ  | mem_req driven from the request buffer, waiting for mem_addr_ok
// ARB_WAIT | address accepted, waiting for mem_data_ok
module cpu_sram_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic pick_en;
  logic inst_gnt;
  logic data_gnt;
  logic complete;

  // Gating with resetn keeps addr_ok low while reset is held.
  assign pick_en = resetn && (state_q == ARB_IDLE);

  arb_priority_pick #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_pick (
    .clk      (clk),
    .resetn   (resetn),
    .pick_en  (pick_en),
    .inst_req (inst_req),
    .data_req (data_req),
    .inst_gnt (inst_gnt),
    .data_gnt (data_gnt)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    complete = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (data_gnt) begin
          owner_d = OWN_DATA;
          wr_d    = data_wr;
          size_d  = data_size;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          state_d = ARB_REQ;
        end else if (inst_gnt) begin
          owner_d = OWN_INST;
          wr_d    = 1'b0;
          size_d  = SZ_WORD;
          addr_d  = inst_addr;
          wdata_d = '0;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        // mem_data_ok without mem_addr_ok is a protocol violation and ignored.
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            complete = 1'b1;
            state_d  = ARB_IDLE;
          end else begin
            state_d = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        if (mem_data_ok) begin
          complete = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    inst_addr_ok = inst_gnt;
    data_addr_ok = data_gnt;
    inst_data_ok = complete && (owner_q == OWN_INST);
    data_data_ok = complete && (owner_q == OWN_DATA);
    // Read data is passed straight through on completion; the non-owner keeps
    // showing its last value.
    inst_rdata_d = inst_data_ok ? mem_rdata : inst_rdata_q;
    data_rdata_d = data_data_ok ? mem_rdata : data_rdata_q;
    inst_rdata   = inst_rdata_d;
    data_rdata   = data_rdata_d;
    mem_req      = (state_q == ARB_REQ);
    mem_wr       = wr_q;
    mem_size     = size_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    busy         = (state_q != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_INST;
      wr_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
module tb_cpu_sram_arbiter;

  localparam int MAX_RUN = 4;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        busy;

  cpu_sram_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(MAX_RUN)
  ) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: one in-flight access, its owner and fields,
  // how far the memory handshake has progressed, and the data-run tally.
  typedef struct {
    bit        own_data;
    bit        wr;
    bit [1:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
  } txn_t;

  txn_t      m_txn;
  bit        m_busy;
  bit        m_acc;
  int        m_run;
  bit [31:0] m_irdata;
  bit [31:0] m_drdata;
  bit        m_dvalid;
  int        a_cnt, d_cnt, a_lat, d_lat;

  // memory responder controls
  bit        rand_lat;
  int        dir_a_lat, dir_d_lat;
  bit        glitch_en;
  bit        force_rd;
  bit [31:0] force_rd_val;

  // what the last tick saw on the DUT
  bit        obs_iaok, obs_daok, obs_idok, obs_ddok, obs_mreq, obs_busy, obs_mwr;
  bit [1:0]  obs_msize;
  bit [31:0] obs_maddr, obs_mwdata, obs_irdata;

  task automatic model_reset();
    m_busy   = 1'b0;
    m_acc    = 1'b0;
    m_run    = 0;
    m_irdata = '0;
    m_drdata = '0;
    m_dvalid = 1'b1;
  endtask

  task automatic tick();
    bit dg, ig, cpl;
    @(negedge clk);
    mem_rdata   = force_rd ? force_rd_val : $urandom;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    if (!m_busy) begin
      if (glitch_en) begin
        mem_addr_ok = ($urandom_range(0, 3) == 0);
        mem_data_ok = ($urandom_range(0, 3) == 0);
      end
    end else if (!m_acc) begin
      if (a_cnt == a_lat) begin
        mem_addr_ok = 1'b1;
        mem_data_ok = (d_lat == 0);
      end else if (glitch_en) begin
        mem_data_ok = ($urandom_range(0, 2) == 0);
      end
    end else begin
      mem_data_ok = (d_cnt == d_lat);
    end
    #1;
    dg  = !m_busy && data_req && !(inst_req && m_run == MAX_RUN);
    ig  = !m_busy && inst_req && !dg;
    cpl = m_busy && mem_data_ok && (m_acc || mem_addr_ok);

    obs_iaok = inst_addr_ok;  obs_daok = data_addr_ok;
    obs_idok = inst_data_ok;  obs_ddok = data_data_ok;
    obs_mreq = mem_req;       obs_busy = busy;
    obs_mwr  = mem_wr;        obs_msize = mem_size;
    obs_maddr = mem_addr;     obs_mwdata = mem_wdata;
    obs_irdata = inst_rdata;

    chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, ig});
    chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, dg});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy && !m_acc});
    chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, cpl && !m_txn.own_data});
    chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, cpl && m_txn.own_data});
    if (m_busy && !m_acc) begin
      chk("mem_addr", mem_addr, m_txn.addr);
      chk("mem_wr", {31'd0, mem_wr}, {31'd0, m_txn.wr});
      chk("mem_size", {30'd0, mem_size}, {30'd0, m_txn.size});
      if (m_txn.wr) chk("mem_wdata", mem_wdata, m_txn.wdata);
    end
    if (cpl && !m_txn.own_data) chk("inst_rdata", inst_rdata, mem_rdata);
    else                        chk("inst_rdata_hold", inst_rdata, m_irdata);
    if (cpl && m_txn.own_data && !m_txn.wr) chk("data_rdata", data_rdata, mem_rdata);
    else if (!(cpl && m_txn.own_data) && m_dvalid) chk("data_rdata_hold", data_rdata, m_drdata);

    if (cpl) begin
      if (!m_txn.own_data) m_irdata = mem_rdata;
      else if (!m_txn.wr) begin m_drdata = mem_rdata; m_dvalid = 1'b1; end
      else m_dvalid = 1'b0;
      m_busy = 1'b0;
    end else if (m_busy && !m_acc) begin
      if (mem_addr_ok) begin m_acc = 1'b1; d_cnt = 1; end
      else a_cnt++;
    end else if (m_busy) begin
      d_cnt++;
    end

    if (dg || ig) begin
      m_txn.own_data = dg;
      m_txn.wr    = dg ? data_wr : 1'b0;
      m_txn.size  = dg ? data_size : 2'd2;
      m_txn.addr  = dg ? data_addr : inst_addr;
      m_txn.wdata = data_wdata;
      m_busy = 1'b1;
      m_acc  = 1'b0;
      a_cnt  = 0;
      d_cnt  = 0;
      a_lat  = rand_lat ? int'($urandom_range(0, 3)) : dir_a_lat;
      d_lat  = rand_lat ? int'($urandom_range(0, 3)) : dir_d_lat;
      if (ig || !inst_req) m_run = 0;
      else if (m_run < MAX_RUN) m_run++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    inst_req = 1'b0;
    data_req = 1'b0;
    k = 0;
    while (m_busy && k < 50) begin tick(); k++; end
    chk("drain_timeout", {31'd0, m_busy}, 32'd0);
    tick();
  endtask

  initial begin
    int nd, k, ndok;
    rand_lat = 1'b0; glitch_en = 1'b0; force_rd = 1'b0; force_rd_val = '0;
    dir_a_lat = 0; dir_d_lat = 0;
    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1234_0000;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
    data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    model_reset();
    #12;
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    inst_req = 1'b0; data_req = 1'b0; mem_data_ok = 1'b0;
    @(posedge clk); #2; resetn = 1'b1;
    @(posedge clk); #1;

    // fetch only, addr_ok one cycle after mem_req, data_ok two cycles later
    dir_a_lat = 1; dir_d_lat = 2;
    force_rd = 1'b1; force_rd_val = 32'h3C01_0001;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    tick();
    chk("t1_aok_c0", {31'd0, obs_iaok}, 32'd1);
    inst_req = 1'b0;
    tick();
    chk("t1_mem_addr", obs_maddr, 32'hBFC0_0000);
    chk("t1_mem_wr", {31'd0, obs_mwr}, 32'd0);
    chk("t1_mem_size", {30'd0, obs_msize}, 32'd2);
    tick(); tick(); tick();
    chk("t1_dok_c4", {31'd0, obs_idok}, 32'd1);
    chk("t1_rdata_c4", obs_irdata, 32'h3C01_0001);
    tick();
    chk("t1_busy_c5", {31'd0, obs_busy}, 32'd0);
    force_rd = 1'b0;

    // simultaneous requests: data write wins, fetch follows after data_ok
    dir_a_lat = 0; dir_d_lat = 1;
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
    data_addr = 32'h0000_0010; data_wdata = 32'h0000_00AB;
    tick();
    chk("t2_data_first", {30'd0, obs_daok, obs_iaok}, 32'd2);
    data_req = 1'b0;
    tick();
    chk("t2_mem_wr", {31'd0, obs_mwr}, 32'd1);
    chk("t2_mem_size", {30'd0, obs_msize}, 32'd0);
    chk("t2_mem_wdata", obs_mwdata, 32'h0000_00AB);
    k = 0;
    while (!obs_ddok && k < 20) begin tick(); k++; end
    chk("t2_ddok_seen", {31'd0, obs_ddok}, 32'd1);
    tick();
    chk("t2_inst_after", {31'd0, obs_iaok}, 32'd1);
    drain();

    // starvation bound with both requesters held high
    rand_lat = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
    for (int r = 0; r < 2; r++) begin
      nd = 0; k = 0;
      do begin
        data_addr = $urandom;
        tick();
        if (obs_daok) nd++;
        k++;
      end while (!obs_iaok && k < 200);
      chk("t3_inst_granted", {31'd0, obs_iaok}, 32'd1);
      chk("t3_data_run", nd, MAX_RUN);
    end
    drain();

    // zero-latency memory: one transaction every two cycles
    rand_lat = 1'b0; dir_a_lat = 0; dir_d_lat = 0;
    data_req = 1'b1; data_wr = 1'b0;
    nd = 0; ndok = 0;
    for (int c = 0; c < 8; c++) begin
      data_addr = 32'h100 + c;
      tick();
      if (obs_daok) nd++;
      if (obs_ddok) ndok++;
    end
    chk("t4_grants", nd, 4);
    chk("t4_done", ndok, 4);
    drain();

    // memory stalls address phase for five cycles
    dir_a_lat = 5; dir_d_lat = 1;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1;
    data_addr = 32'h0000_2000; data_wdata = 32'h0000_55AA;
    tick();
    inst_req = 1'b1; data_addr = 32'hFFFF_0000; data_wdata = 32'h1111_1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_mem_req", {31'd0, obs_mreq}, 32'd1);
      chk("t5_mem_addr", obs_maddr, 32'h0000_2000);
      chk("t5_mem_wdata", obs_mwdata, 32'h0000_55AA);
      chk("t5_no_aok", {30'd0, obs_iaok, obs_daok}, 32'd0);
    end
    drain();

    // reset while waiting for read data
    dir_a_lat = 0; dir_d_lat = 5;
    inst_req = 1'b1; inst_addr = 32'h0000_4000;
    tick();
    inst_req = 1'b0;
    tick(); tick();
    chk("t6_in_wait", {31'd0, obs_busy}, 32'd1);
    #2;
    resetn = 1'b0; mem_data_ok = 1'b1; inst_req = 1'b1;
    #1;
    chk("t6_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    chk("t6_aok", {31'd0, inst_addr_ok}, 32'd0);
    model_reset();
    @(posedge clk); #2;
    resetn = 1'b1; mem_data_ok = 1'b0;
    inst_addr = 32'h0000_5000;
    tick();
    chk("t6_regrant", {31'd0, obs_iaok}, 32'd1);
    drain();

    // random traffic with protocol-violating memory glitches
    rand_lat = 1'b1; glitch_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      inst_req   = ($urandom_range(0, 2) != 0);
      inst_addr  = $urandom;
      data_req   = ($urandom_range(0, 1) != 0);
      data_wr    = $urandom_range(0, 1);
      data_size  = 2'($urandom_range(0, 2));
      data_addr  = $urandom;
      data_wdata = $urandom;
      tick();
    end
    glitch_en = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_sram_arbiter.md
Name: cpu_sram_arbiter

Overview:
- Shares a single sram-like memory port between the pipeline's instruction-fetch requester and its data-access requester.
- Sits between the CPU core (fetch / mem stages) and the SoC memory/bridge.
- Serialises transactions with one outstanding access at a time.
- Data side has priority; a bounded-starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width on all three interfaces
- DATA_W, 32, data width on all three interfaces
- MAX_DATA_RUN, 4, consecutive data grants allowed while an inst request waits (range 1..15)

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- inst_req  in  1  fetch request (read only)
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request
- data_wr  in  1  1=write, 0=read
- data_size  in  2  0=byte, 1=half, 2=word
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  read data valid / write complete
- data_rdata  out  DATA_W  read data
- mem_req  out  1  memory request
- mem_wr  out  1  memory write
- mem_size  out  2  memory size
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (resetn=0, asynchronous):
  - State=IDLE, owner=INST, run counter=0, request buffer=0.
  - All outputs 0.
  - Reset mid-transaction discards it; the memory side is reset concurrently by the SoC.
- FSM states:
  - IDLE: no transaction.
  - REQ: mem_req=1, driven from the request buffer.
  - WAIT: waiting for mem_data_ok.
- IDLE arbitration (combinational grant):
  - Data wins if data_req=1 and NOT (inst_req=1 and run==MAX_DATA_RUN).
  - Otherwise inst wins if inst_req=1.
  - The granted requester gets addr_ok=1 the same cycle; the other gets 0.
  - On grant, latch wr/size/addr/wdata and owner into the buffer; next state REQ.
  - A granted inst transaction latches wr=0 and size=2.
- Run counter:
  - Increments on a data grant while inst_req=1, saturating at MAX_DATA_RUN.
  - Clears on any inst grant, or on a data grant with inst_req=0.
- REQ:
  - mem_* are driven from the buffer and held stable until mem_addr_ok.
  - mem_addr_ok=1 and mem_data_ok=0: go to WAIT.
  - mem_addr_ok=1 and mem_data_ok=1 in the same cycle (zero-latency memory): complete, go to IDLE.
- WAIT: mem_data_ok=1 completes the transaction; go to IDLE.
- Completion routing (combinational, same cycle as mem_data_ok):
  - owner_data_ok=1; owner_rdata=mem_rdata.
  - The non-owner's data_ok=0 and its rdata holds its last value.
  - Write completion asserts data_data_ok; data_rdata is don't-care.
- Timing:
  - No new grant in the cycle of completion; the earliest next addr_ok is the cycle after data_ok.
  - Minimum transaction = 2 cycles (grant, then REQ with addr_ok+data_ok).
- Interface rules:
  - mem_data_ok in IDLE, or in REQ without mem_addr_ok, is a protocol violation; it is ignored and never routed.
  - Requesters may drop req without addr_ok; nothing is latched in that case.
  - addr_ok is never asserted outside IDLE.

Decomposition:
- Shared package cpu_bus_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum ARB_IDLE/ARB_REQ/ARB_WAIT.
  - owner constants OWN_INST/OWN_DATA.
- One natural sub-module: arb_priority_pick.
  - Combinational grant plus saturating run counter.
- Request buffer and FSM stay in the top.

Test Plan:
- Inst only: inst_req=1, addr 0xBFC00000; memory addr_ok the cycle after mem_req, data_ok 2 cycles later with 0x3C010001 -> inst_addr_ok at cycle 0, mem_addr=0xBFC00000 with mem_wr=0/size=2, inst_data_ok with rdata 0x3C010001 at cycle 4, busy 0 at cycle 5.
- Simultaneous: inst_req=data_req=1; data write 0x00000010, size=0, wdata 0xAB -> data granted first (mem_wr=1, size=0); inst granted the cycle after data_data_ok.
- Starvation bound: data_req held high, inst_req high, MAX_DATA_RUN=4 -> exactly 4 data transactions, then the inst grant; run counter reads 0 afterwards.
- Zero-latency memory: mem_addr_ok and mem_data_ok both 1 in the first REQ cycle -> data_ok that cycle, state IDLE next cycle, 2-cycle throughput.
- Stall: mem_addr_ok held 0 for 5 cycles -> mem_req/addr/wdata stable all 5 cycles; no addr_ok to either requester.
- Reset mid-WAIT: resetn low asynchronously -> mem_req, busy, and both data_ok outputs 0 immediately; after release, a new inst_req is granted from IDLE.
